// File: rtl/pipeline_ctrl_unit_pkg.sv
// pipe_ctrl_pkg: shared shadow-pipeline types and helpers for pipeline_ctrl_unit.
package pipe_ctrl_pkg;
   localparam int REG_AW_MAX = 8;
   localparam int FWD_REGFILE = 0;
   typedef struct packed {
      logic valid;
      logic [REG_AW_MAX-1:0] rd;
      logic reg_we;
      logic mem_re;
   } stage_info_t;
   typedef struct packed {
      stage_info_t st;
      logic [REG_AW_MAX-1:0] rs1, rs2;
      logic rs1_used, rs2_used;
   } ex_info_t;
   function automatic int sel_w(input int mem_stages);
      return $clog2(mem_stages + 2);
   endfunction
endpackage

// File: rtl/pipeline_ctrl_unit_fwd_select.sv
// fwd_select: priority matcher picking the youngest M1..WB producer of one EX source.
module fwd_select
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_STAGES = 1,
   parameter int SW = sel_w(MEM_STAGES)
) (
   input logic ex_valid,
   input logic used,
   input logic [REG_AW_MAX-1:0] src,
   input stage_info_t [MEM_STAGES:0] st,
   output logic [SW-1:0] sel,
   output logic load_hit
);
   // Scan oldest to youngest so the youngest match overwrites the rest.
   always_comb begin
      sel = SW'(FWD_REGFILE);
      load_hit = 1'b0;
      for (int k = MEM_STAGES; k >= 0; k--)
         if (ex_valid && used && st[k].valid && st[k].reg_we && st[k].rd != '0 && st[k].rd == src) begin
            sel = SW'(k + 1);
            load_hit = st[k].mem_re && k < MEM_STAGES;
         end
   end
endmodule

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: hazard, forwarding and stall/flush control for an in-order pipeline,
// tracking in-flight instructions EX..WB in a shadow pipeline.
module pipeline_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int MEM_STAGES = 1,
   parameter int CNT_W = 32
) (
   input logic clk,
   input logic rst,
   input logic id_valid,
   input logic [REG_AW-1:0] id_rs1,
   input logic [REG_AW-1:0] id_rs2,
   input logic id_rs1_used,
   input logic id_rs2_used,
   input logic [REG_AW-1:0] id_rd,
   input logic id_reg_we,
   input logic id_mem_re,
   input logic ex_branch_taken,
   input logic mem_busy,
   output logic pc_we,
   output logic if_id_we,
   output logic id_ex_we,
   output logic ex_mem_we,
   output logic mem_wb_we,
   output logic if_id_clear,
   output logic id_ex_clear,
   output logic [sel_w(MEM_STAGES)-1:0] ex_fwd1_sel,
   output logic [sel_w(MEM_STAGES)-1:0] ex_fwd2_sel,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);
   localparam int SW = sel_w(MEM_STAGES);
   ex_info_t ex_q;
   stage_info_t [MEM_STAGES:0] st_q;
   logic [REG_AW_MAX-1:0] rs1, rs2;
   logic load_stall, flush, stall, lh1, lh2;
   logic [SW-1:0] sel1, sel2;
   function automatic logic dep(input stage_info_t s, input logic [REG_AW_MAX-1:0] a, b, input logic ua, ub);
      return s.valid && s.mem_re && s.rd != '0 && ((ua && a == s.rd) || (ub && b == s.rd));
   endfunction
   assign rs1 = REG_AW_MAX'(id_rs1);
   assign rs2 = REG_AW_MAX'(id_rs2);
   // Load data is only usable from WB, so loads in EX..M(n-1) must hold the consumer in ID.
   always_comb begin
      load_stall = id_valid && dep(ex_q.st, rs1, rs2, id_rs1_used, id_rs2_used);
      for (int k = 0; k < MEM_STAGES - 1; k++)
         load_stall = load_stall || (id_valid && dep(st_q[k], rs1, rs2, id_rs1_used, id_rs2_used));
   end
   assign flush = !mem_busy && ex_branch_taken;
   assign stall = !mem_busy && !ex_branch_taken && load_stall;
   assign pc_we = rst && !mem_busy && !stall;
   assign if_id_we = pc_we;
   assign id_ex_we = rst && !mem_busy;
   assign ex_mem_we = id_ex_we;
   assign mem_wb_we = id_ex_we;
   assign if_id_clear = !rst || flush;
   assign id_ex_clear = !rst || flush || stall;
   assign ex_fwd1_sel = rst ? sel1 : SW'(FWD_REGFILE);
   assign ex_fwd2_sel = rst ? sel2 : SW'(FWD_REGFILE);
   fwd_select #(.MEM_STAGES(MEM_STAGES), .SW(SW)) u_fwd1 (
      .ex_valid(ex_q.st.valid), .used(ex_q.rs1_used), .src(ex_q.rs1), .st(st_q), .sel(sel1), .load_hit(lh1)
   );
   fwd_select #(.MEM_STAGES(MEM_STAGES), .SW(SW)) u_fwd2 (
      .ex_valid(ex_q.st.valid), .used(ex_q.rs2_used), .src(ex_q.rs2), .st(st_q), .sel(sel2), .load_hit(lh2)
   );
   always_ff @(posedge clk) begin
      if (!rst) begin
         ex_q <= '0;
         st_q <= '0;
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (!mem_busy) begin
            st_q <= {st_q[MEM_STAGES-1:0], ex_q.st};
            ex_q.st.valid <= id_valid && !flush && !stall;
            ex_q.st.rd <= REG_AW_MAX'(id_rd);
            ex_q.st.reg_we <= id_reg_we;
            ex_q.st.mem_re <= id_mem_re;
            ex_q.rs1 <= rs1;
            ex_q.rs2 <= rs2;
            ex_q.rs1_used <= id_rs1_used;
            ex_q.rs2_used <= id_rs2_used;
         end
         if ((mem_busy || stall) && !(&stall_cycles))
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (flush && !(&flush_events))
            flush_events <= flush_events + CNT_W'(1);
      end
   end
   no_load_forward: assert property (@(posedge clk) disable iff (!rst) !(lh1 || lh2));
endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// tb_pipeline_ctrl_unit: directed checks of hazard, forwarding, flush and freeze control
// for a one-memory-stage unit (a_*) and a two-stage unit with 2-bit counters (b_*).
module tb_pipeline_ctrl_unit;
   logic clk = 1'b0, rst = 1'b0;
   logic id_valid, id_rs1_used, id_rs2_used, id_reg_we, id_mem_re, ex_branch_taken, mem_busy;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic a_pc_we, a_if_id_we, a_id_ex_we, a_ex_mem_we, a_mem_wb_we, a_if_id_clear, a_id_ex_clear;
   logic b_pc_we, b_if_id_we, b_id_ex_we, b_ex_mem_we, b_mem_wb_we, b_if_id_clear, b_id_ex_clear;
   logic [1:0] a_fwd1, a_fwd2, b_fwd1, b_fwd2;
   logic [31:0] a_stall, a_flush;
   logic [1:0] b_stall, b_flush;
   int n_run = 0, n_fail = 0;

   always #5 clk = ~clk;

   pipeline_ctrl_unit #(.REG_AW(5), .MEM_STAGES(1), .CNT_W(32)) u_a (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_we(id_reg_we),
      .id_mem_re(id_mem_re), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_we(a_pc_we), .if_id_we(a_if_id_we), .id_ex_we(a_id_ex_we), .ex_mem_we(a_ex_mem_we),
      .mem_wb_we(a_mem_wb_we), .if_id_clear(a_if_id_clear), .id_ex_clear(a_id_ex_clear),
      .ex_fwd1_sel(a_fwd1), .ex_fwd2_sel(a_fwd2), .stall_cycles(a_stall), .flush_events(a_flush)
   );

   pipeline_ctrl_unit #(.REG_AW(5), .MEM_STAGES(2), .CNT_W(2)) u_b (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_we(id_reg_we),
      .id_mem_re(id_mem_re), .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
      .pc_we(b_pc_we), .if_id_we(b_if_id_we), .id_ex_we(b_id_ex_we), .ex_mem_we(b_ex_mem_we),
      .mem_wb_we(b_mem_wb_we), .if_id_clear(b_if_id_clear), .id_ex_clear(b_id_ex_clear),
      .ex_fwd1_sel(b_fwd1), .ex_fwd2_sel(b_fwd2), .stall_cycles(b_stall), .flush_events(b_flush)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic setid(input logic v, input int rd, input logic we, re, input int r1, input logic u1, input int r2, input logic u2);
      id_valid = v;
      id_rd = 5'(rd);
      id_reg_we = we;
      id_mem_re = re;
      id_rs1 = 5'(r1);
      id_rs1_used = u1;
      id_rs2 = 5'(r2);
      id_rs2_used = u2;
   endtask

   task automatic nop();
      setid(1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
   endtask

   task automatic drain();
      repeat (4) begin
         nop();
         @(negedge clk);
      end
   endtask

   initial begin
      mem_busy = 1'b0;
      ex_branch_taken = 1'b0;
      nop();
      @(negedge clk);
      #1;
      chk("rst_pc_we", a_pc_we, 0);
      chk("rst_if_id_we", a_if_id_we, 0);
      chk("rst_id_ex_we", a_id_ex_we, 0);
      chk("rst_ex_mem_we", a_ex_mem_we, 0);
      chk("rst_mem_wb_we", a_mem_wb_we, 0);
      chk("rst_if_id_clear", a_if_id_clear, 1);
      chk("rst_id_ex_clear", a_id_ex_clear, 1);
      chk("rst_fwd1", a_fwd1, 0);
      chk("rst_stall_cnt", a_stall, 0);
      chk("rst_flush_cnt", a_flush, 0);
      rst = 1'b1;
      @(negedge clk);
      // add x5,x1,x2 ; sub x6,x5,x1 back to back
      setid(1, 5, 1, 0, 1, 1, 2, 1);
      #1 chk("run_pc_we", a_pc_we, 1);
      chk("run_id_ex_clear", a_id_ex_clear, 0);
      @(negedge clk);
      setid(1, 6, 1, 0, 5, 1, 1, 1);
      #1 chk("raw_no_stall", a_pc_we, 1);
      @(negedge clk);
      nop();
      #1 chk("raw_m1_fwd1", a_fwd1, 1);
      chk("raw_m1_fwd2", a_fwd2, 0);
      @(negedge clk);
      drain();
      // add x5 ; unrelated ; sub x6,x5,x1
      setid(1, 5, 1, 0, 1, 1, 2, 1);
      @(negedge clk);
      setid(1, 3, 1, 0, 4, 1, 4, 1);
      @(negedge clk);
      setid(1, 6, 1, 0, 5, 1, 1, 1);
      #1 chk("raw_gap_no_stall", a_pc_we, 1);
      @(negedge clk);
      nop();
      #1 chk("raw_wb_fwd1", a_fwd1, 2);
      chk("raw_wb_fwd2", a_fwd2, 0);
      chk("raw_stall_cnt", a_stall, 0);
      @(negedge clk);
      drain();
      // lw x7,0(x2) ; add x8,x7,x7
      setid(1, 7, 1, 1, 2, 1, 0, 0);
      #1 chk("lu_issue", a_pc_we, 1);
      @(negedge clk);
      setid(1, 8, 1, 0, 7, 1, 7, 1);
      #1 chk("lu_pc_we", a_pc_we, 0);
      chk("lu_if_id_we", a_if_id_we, 0);
      chk("lu_id_ex_clear", a_id_ex_clear, 1);
      chk("lu_ex_mem_we", a_ex_mem_we, 1);
      chk("lu_if_id_clear", a_if_id_clear, 0);
      @(negedge clk);
      #1 chk("lu_release", a_pc_we, 1);
      @(negedge clk);
      nop();
      #1 chk("lu_fwd1", a_fwd1, 2);
      chk("lu_fwd2", a_fwd2, 2);
      chk("lu_stall_cnt", a_stall, 1);
      @(negedge clk);
      drain();
      // lw x0 ; add x1,x0,x0 ; lw x5 ; lui x5
      setid(1, 0, 1, 1, 2, 1, 0, 0);
      @(negedge clk);
      setid(1, 1, 1, 0, 0, 1, 0, 1);
      #1 chk("x0_no_stall", a_pc_we, 1);
      @(negedge clk);
      setid(1, 5, 1, 1, 2, 1, 0, 0);
      #1 chk("x0_fwd1", a_fwd1, 0);
      chk("x0_fwd2", a_fwd2, 0);
      @(negedge clk);
      setid(1, 5, 1, 0, 5, 0, 5, 0);
      #1 chk("unused_no_stall", a_pc_we, 1);
      @(negedge clk);
      nop();
      #1 chk("unused_fwd1", a_fwd1, 0);
      chk("unused_fwd2", a_fwd2, 0);
      chk("unused_stall_cnt", a_stall, 1);
      @(negedge clk);
      drain();
      // lw x7 in EX, taken branch while lw x9,0(x7) sits in ID
      setid(1, 7, 1, 1, 2, 1, 0, 0);
      @(negedge clk);
      setid(1, 9, 1, 1, 7, 1, 0, 0);
      ex_branch_taken = 1'b1;
      #1 chk("br_if_id_clear", a_if_id_clear, 1);
      chk("br_id_ex_clear", a_id_ex_clear, 1);
      chk("br_pc_we", a_pc_we, 1);
      chk("br_id_ex_we", a_id_ex_we, 1);
      @(negedge clk);
      ex_branch_taken = 1'b0;
      setid(1, 10, 1, 0, 9, 1, 9, 1);
      #1 chk("br_flush_cnt", a_flush, 1);
      chk("br_stall_cnt", a_stall, 1);
      chk("br_ex_invalid", a_pc_we, 1);
      @(negedge clk);
      nop();
      #1 chk("br_fwd1", a_fwd1, 0);
      @(negedge clk);
      drain();
      // taken branch frozen by mem_busy for three cycles
      setid(1, 3, 1, 0, 1, 1, 2, 1);
      ex_branch_taken = 1'b1;
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1 chk("busy_pc_we", a_pc_we, 0);
         chk("busy_mem_wb_we", a_mem_wb_we, 0);
         chk("busy_if_id_clear", a_if_id_clear, 0);
         chk("busy_id_ex_clear", a_id_ex_clear, 0);
         @(negedge clk);
      end
      mem_busy = 1'b0;
      #1 chk("busy_flush_fires", a_if_id_clear, 1);
      chk("busy_flush_pc_we", a_pc_we, 1);
      chk("busy_stall_cnt", a_stall, 4);
      @(negedge clk);
      ex_branch_taken = 1'b0;
      nop();
      #1 chk("busy_flush_cnt", a_flush, 2);
      @(negedge clk);
      // reset in the middle of a load-use stall and a freeze
      setid(1, 7, 1, 1, 2, 1, 0, 0);
      @(negedge clk);
      setid(1, 8, 1, 0, 7, 1, 7, 1);
      mem_busy = 1'b1;
      rst = 1'b0;
      #1 chk("midrst_pc_we", a_pc_we, 0);
      chk("midrst_if_id_clear", a_if_id_clear, 1);
      chk("midrst_id_ex_clear", a_id_ex_clear, 1);
      chk("midrst_mem_wb_we", a_mem_wb_we, 0);
      @(negedge clk);
      #1 chk("midrst_stall_cnt", a_stall, 0);
      chk("midrst_flush_cnt", a_flush, 0);
      chk("midrst_b_stall_cnt", b_stall, 0);
      rst = 1'b1;
      mem_busy = 1'b0;
      #1 chk("midrst_entries_invalid", a_pc_we, 1);
      chk("midrst_b_entries_invalid", b_pc_we, 1);
      @(negedge clk);
      drain();
      // two memory stages: lw x7 ; add x8,x7,x7
      setid(1, 7, 1, 1, 2, 1, 0, 0);
      #1 chk("ms2_issue", b_pc_we, 1);
      @(negedge clk);
      setid(1, 8, 1, 0, 7, 1, 7, 1);
      #1 chk("ms2_stall1", b_pc_we, 0);
      @(negedge clk);
      #1 chk("ms2_stall2", b_pc_we, 0);
      chk("ms2_id_ex_clear2", b_id_ex_clear, 1);
      @(negedge clk);
      #1 chk("ms2_release", b_pc_we, 1);
      @(negedge clk);
      nop();
      #1 chk("ms2_fwd1", b_fwd1, 3);
      chk("ms2_fwd2", b_fwd2, 3);
      chk("ms2_stall_cnt", b_stall, 2);
      mem_busy = 1'b1;
      repeat (3) @(negedge clk);
      mem_busy = 1'b0;
      #1 chk("sat_stall_cnt", b_stall, 3);
      chk("wide_stall_cnt", a_stall, 4);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
